// File: rtl/igbt_seq_ctrl.sv
// H-bridge IGBT sequencer: bootstrap precharge, edge-aligned PWM run,
// drain-down stop and latched fault handling. All outputs are registered.
module igbt_seq_ctrl #(
  parameter int unsigned PERIOD      = 500,
  parameter int unsigned BOOT_CYCLES = 200,
  parameter int unsigned MIN_PULSE   = 8,
  parameter int unsigned STOP_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run_req,
  input  logic       fault_in,
  input  logic       fault_clr,
  input  logic [8:0] duty_l,
  input  logic [8:0] duty_r,
  output logic [1:0] igbt_control,
  output logic       start_stop,
  output logic       err_unit,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StPrechg = 3'd1,
    StRun    = 3'd2,
    StStop   = 3'd3,
    StFault  = 3'd4
  } state_e;

  localparam logic [8:0] PerVal   = 9'(PERIOD);
  localparam logic [8:0] PerLast  = 9'(PERIOD - 1);
  localparam logic [8:0] BootLast = 9'(BOOT_CYCLES - 1);
  localparam logic [8:0] StopLast = 9'(STOP_CYCLES - 1);
  localparam logic [8:0] MinPulse = 9'(MIN_PULSE);
  localparam logic [8:0] HiLimit  = 9'(PERIOD - MIN_PULSE);

  state_e     state_q, state_d;
  logic [8:0] cnt_q, cnt_d;
  logic [8:0] dl_q, dl_d;
  logic [8:0] dr_q, dr_d;
  logic       fault_meta_q, fault_s_q;
  logic [1:0] igbt_d;
  logic       ss_d, err_d;

  // Saturate to the period, then snap slivers shorter than MIN_PULSE to fully off/on.
  function automatic logic [8:0] shape_duty(input logic [8:0] d);
    logic [8:0] s;
    s = (d > PerVal) ? PerVal : d;
    if (s < MinPulse) begin
      s = '0;
    end else if (s > HiLimit) begin
      s = PerVal;
    end
    return s;
  endfunction

  // Two-flop synchronizer for the asynchronous fault input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_meta_q <= 1'b0;
      fault_s_q    <= 1'b0;
    end else begin
      fault_meta_q <= fault_in;
      fault_s_q    <= fault_meta_q;
    end
  end

  // Next-state, shared phase/carrier counter and duty latch logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dl_d    = dl_q;
    dr_d    = dr_q;
    if (fault_s_q) begin
      state_d = StFault;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (run_req) begin
            state_d = StPrechg;
            cnt_d   = '0;
          end
        end
        StPrechg: begin
          if (cnt_q == BootLast) begin
            state_d = StRun;
            cnt_d   = '0;
            dl_d    = shape_duty(duty_l);
            dr_d    = shape_duty(duty_r);
          end else begin
            cnt_d = cnt_q + 9'd1;
          end
        end
        StRun: begin
          if (cnt_q == PerLast) begin
            cnt_d = '0;
            if (!run_req) begin
              state_d = StStop;
            end else begin
              dl_d = shape_duty(duty_l);
              dr_d = shape_duty(duty_r);
            end
          end else begin
            cnt_d = cnt_q + 9'd1;
          end
        end
        StStop: begin
          if (cnt_q == StopLast) begin
            state_d = StIdle;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 9'd1;
          end
        end
        StFault: begin
          cnt_d = '0;
          // fault_s is known low here; a clear with run_req high is ignored.
          if (fault_clr && !run_req) begin
            state_d = StIdle;
          end
        end
        default: begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs computed from next-state values so they line up with state_o.
  always_comb begin
    igbt_d = 2'b00;
    if (state_d == StRun) begin
      igbt_d = {cnt_d < dl_d, cnt_d < dr_d};
    end
    ss_d  = (state_d == StPrechg) || (state_d == StRun) || (state_d == StStop);
    err_d = (state_d == StFault);
  end

  // State, counter, duty latches and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      dl_q         <= '0;
      dr_q         <= '0;
      igbt_control <= 2'b00;
      start_stop   <= 1'b0;
      err_unit     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      dl_q         <= dl_d;
      dr_q         <= dr_d;
      igbt_control <= igbt_d;
      start_stop   <= ss_d;
      err_unit     <= err_d;
    end
  end

  assign state_o = state_q;

endmodule

// File: doc/igbt_seq_ctrl.md
IGBT_SEQ_CTRL -- requirements
Module: igbt_seq_ctrl

Interface
REQ-001 Parameter PERIOD, default 500, carrier period in clk cycles (legal range 4..511).
REQ-002 Parameter BOOT_CYCLES, default 200, bootstrap precharge length in cycles (legal range 1..511).
REQ-003 Parameter MIN_PULSE, default 8, minimum on/off pulse width in cycles (legal range 0..PERIOD/2).
REQ-004 Parameter STOP_CYCLES, default 16, drain time after stop in cycles (legal range 1..511).
REQ-005 clk  input  1  system clock; all logic on its rising edge.
REQ-006 rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-007 run_req  input  1  level request from the host to run the bridge.
REQ-008 fault_in  input  1  asynchronous external fault, active-high.
REQ-009 fault_clr  input  1  single-cycle pulse that acknowledges a latched fault.
REQ-010 duty_l  input  9  left-leg on-count compare value.
REQ-011 duty_r  input  9  right-leg on-count compare value.
REQ-012 igbt_control  output  2  bridge command: bit1 = left upper on, bit0 = right upper on.
REQ-013 start_stop  output  1  enables the bridge output stage.
REQ-014 err_unit  output  1  unit fault flag.
REQ-015 state_o  output  3  current state encoding: IDLE=0, PRECHG=1, RUN=2, STOP=3, FAULT=4.

Function
REQ-016 fault_in shall pass through a 2-flop synchronizer; fault_s is the second flop.
REQ-017 The FSM shall have exactly the states IDLE, PRECHG, RUN, STOP and FAULT.
REQ-018 fault_s=1 in any state shall force FAULT on the next edge; this has the highest priority.
REQ-019 IDLE -> PRECHG when run_req=1 and fault_s=0; the phase counter loads 0.
REQ-020 PRECHG: igbt_control=00 (both lower legs on); after BOOT_CYCLES cycles -> RUN, carrier count=0, duties latched.
REQ-021 RUN: 9-bit carrier counts 0..PERIOD-1 and wraps to 0.
REQ-022 Duties shall be sampled only on RUN entry and at the cycle where carrier=PERIOD-1; mid-period changes have no effect.
REQ-023 Latched duty processing: values >PERIOD saturate to PERIOD; values <MIN_PULSE become 0; values >PERIOD-MIN_PULSE become PERIOD.
REQ-024 In RUN, igbt_control[1] = (carrier < dl_lat) and igbt_control[0] = (carrier < dr_lat), registered with 1-cycle latency.
REQ-025 RUN -> STOP only at carrier=PERIOD-1 with run_req=0; a run_req drop mid-period completes the period.
REQ-026 STOP: igbt_control=00; after STOP_CYCLES cycles -> IDLE, even if run_req has re-asserted; restart goes through PRECHG.
REQ-027 FAULT: igbt_control=00, start_stop=0, err_unit=1; all counters clear to 0.
REQ-028 FAULT -> IDLE only when fault_clr=1, fault_s=0 and run_req=0 in the same cycle; otherwise fault_clr is ignored.
REQ-029 start_stop=1 in PRECHG, RUN and STOP; start_stop=0 in IDLE and FAULT. err_unit=1 only in FAULT.
REQ-030 All outputs shall be registered; igbt_control=00 in every non-RUN state.

Reset
REQ-031 rst_n=0 shall asynchronously force: state IDLE, igbt_control=00, start_stop=0, err_unit=0, state_o=0, all counters, synchronizer and duty latches=0.
REQ-032 Reset shall be honoured mid-operation in any state; after release, outputs remain at reset values until run_req is sampled in IDLE.

Verification (PERIOD=10, BOOT_CYCLES=4, MIN_PULSE=2, STOP_CYCLES=3)
REQ-033 Case 1: run_req=1, duty_l=5, duty_r=3. Required: 4 cycles of PRECHG with 00, then RUN; per period bit1 high 5 cycles and bit0 high 3 cycles; start_stop=1.
REQ-034 Case 2: duty_l changes 5->7 at carrier=4. Required: current period keeps 5; the next period shows 7.
REQ-035 Case 3: duty_l=1 and duty_r=9. Required: bit1 never high; bit0 constantly high, since 9 > PERIOD-MIN_PULSE clamps to 10.
REQ-036 Case 4: run_req drops at carrier=2. Required: the period completes, then 3 cycles of STOP with 00, then IDLE with start_stop=0.
REQ-037 Case 5: fault_in pulses during RUN. Required: FAULT within 3 edges with 00, err_unit=1. fault_clr while run_req=1 is ignored; fault_clr with run_req=0 returns to IDLE.
REQ-038 Case 6: rst_n asserted mid-RUN. Required: igbt_control=00, start_stop=0 and state_o=0 immediately, without waiting for a clock edge.
